// File: rtl/cmos_pixel_packer.sv
// cmos_pixel_packer: skips the first SKIP_FRAMES sensor frames, then packs
// four 16-bit pixels into each 64-bit word for the frame-buffer FIFO.
// It also generates frame start/done pulses and sticky error flags.
//
// Handshake: de_i is a valid-only strobe and has no ready; every pixel
// presented with de_i=1 is taken on that edge. fifo_wr_en is a valid strobe
// toward the FIFO. fifo_full acts as the inverted ready and is sampled on the
// edge that would issue the write. If fifo_full=1 on that edge, the word is
// dropped rather than stalled, and overflow is set.
module cmos_pixel_packer #(
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int SKIP_FRAMES = 10
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        vsync_i,
  input  logic        de_i,
  input  logic [15:0] pdata_i,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [63:0] fifo_wdata,
  output logic        frame_start,
  output logic        frame_done,
  output logic [11:0] line_cnt,
  output logic        overflow,
  output logic        frame_err,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [15:0] SKIP_LIM = 16'(SKIP_FRAMES);
  localparam logic [15:0] PX_LIM   = 16'(IMG_WIDTH);
  localparam logic [11:0] LINE_LIM = 12'(IMG_HEIGHT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_vs_d;
  logic        r_de_d;
  logic [15:0] r_skip_cnt;
  logic [1:0]  r_pack_cnt;
  logic [15:0] r_px_cnt;
  logic [11:0] r_line_cnt;
  logic [63:0] r_word;
  logic        r_wr_en;
  logic [63:0] r_wdata;
  logic        r_frame_start;
  logic        r_frame_done;
  logic        r_overflow;
  logic        r_frame_err;

  logic        w_vs_rise;
  logic        w_line_end;
  logic        w_start;
  logic        w_store;
  logic        w_line_done;
  logic        w_last_line;
  logic        w_skip_inc;
  logic        w_err;
  logic        w_issue;
  logic [63:0] w_word_nxt;
  logic [63:0] w_issue_word;
  logic [11:0] w_line_inc;

  assign w_vs_rise  = vsync_i & ~r_vs_d;
  assign w_line_end = ~de_i & r_de_d;
  assign w_line_inc = r_line_cnt + 12'd1;

  // State register
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and per-cycle control strobes. vs_rise has priority over both
  // a pixel and a line end in the same cycle, so any partial word is discarded.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_store     = 1'b0;
    w_line_done = 1'b0;
    w_last_line = 1'b0;
    w_skip_inc  = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_vs_rise) begin
          if (r_skip_cnt == SKIP_LIM) begin
            w_state_nxt = S_ACTIVE;
            w_start     = 1'b1;
          end else begin
            w_skip_inc = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        if (w_vs_rise) begin
          w_start = 1'b1;
          w_err   = 1'b1;
        end else if (de_i) begin
          w_store = 1'b1;
        end else if (w_line_end) begin
          w_line_done = 1'b1;
          if (r_px_cnt != PX_LIM) w_err = 1'b1;
          if (w_line_inc == LINE_LIM) begin
            w_last_line = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (w_vs_rise) begin
          w_state_nxt = S_ACTIVE;
          w_start     = 1'b1;
        end else if (de_i) begin
          w_err = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Insert the incoming pixel into its lane. Lane 0 starts a fresh word with
  // all upper lanes zeroed, so a line-end flush needs no extra masking.
  always_comb begin
    w_word_nxt = (r_pack_cnt == 2'd0) ? 64'd0 : r_word;
    case (r_pack_cnt)
      2'd0:    w_word_nxt[15:0]  = pdata_i;
      2'd1:    w_word_nxt[31:16] = pdata_i;
      2'd2:    w_word_nxt[47:32] = pdata_i;
      default: w_word_nxt[63:48] = pdata_i;
    endcase
  end

  // A write issues on the fourth pixel of a group or on a partial-word flush.
  always_comb begin
    w_issue      = (w_store && (r_pack_cnt == 2'd3)) ||
                   (w_line_done && (r_pack_cnt != 2'd0));
    w_issue_word = w_store ? w_word_nxt : r_word;
  end

  // Datapath: edge detectors, counters, packing register, registered outputs
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d        <= 1'b0;
      r_de_d        <= 1'b0;
      r_skip_cnt    <= 16'd0;
      r_pack_cnt    <= 2'd0;
      r_px_cnt      <= 16'd0;
      r_line_cnt    <= 12'd0;
      r_word        <= 64'd0;
      r_wr_en       <= 1'b0;
      r_wdata       <= 64'd0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_overflow    <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_vs_d        <= vsync_i;
      r_de_d        <= de_i;
      r_frame_start <= w_start;
      r_frame_done  <= w_last_line;
      r_wr_en       <= w_issue && !fifo_full;
      if (w_issue && !fifo_full) r_wdata <= w_issue_word;
      if (w_issue && fifo_full)  r_overflow <= 1'b1;
      if (w_err)                 r_frame_err <= 1'b1;
      if (w_skip_inc)            r_skip_cnt <= r_skip_cnt + 16'd1;
      if (w_start) begin
        r_pack_cnt <= 2'd0;
        r_px_cnt   <= 16'd0;
        r_line_cnt <= 12'd0;
      end else if (w_store) begin
        r_pack_cnt <= r_pack_cnt + 2'd1;
        // Saturate so an absurdly long line cannot wrap back to IMG_WIDTH.
        if (r_px_cnt != 16'hFFFF) r_px_cnt <= r_px_cnt + 16'd1;
        r_word     <= w_word_nxt;
      end else if (w_line_done) begin
        r_pack_cnt <= 2'd0;
        r_px_cnt   <= 16'd0;
        r_line_cnt <= w_line_inc;
      end
    end
  end

  assign fifo_wr_en  = r_wr_en;
  assign fifo_wdata  = r_wdata;
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;
  assign line_cnt    = r_line_cnt;
  assign overflow    = r_overflow;
  assign frame_err   = r_frame_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cmos_pixel_packer.sv
// Bench for cmos_pixel_packer using an 8x2 image with two skipped frames.
module tb_cmos_pixel_packer;

  logic        pclk;
  logic        rst_n;
  logic        vsync_i;
  logic        de_i;
  logic [15:0] pdata_i;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [63:0] fifo_wdata;
  logic        frame_start;
  logic        frame_done;
  logic [11:0] line_cnt;
  logic        overflow;
  logic        frame_err;
  logic [1:0]  o_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int n_writes = 0;
  int n_fs = 0;
  int n_fd = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    int          n;
    logic [15:0] px [8];
    logic [7:0]  full;
    int          nw;
    logic [63:0] w [2];
    logic        exp_err;
    logic        exp_ovf;
  } line_vec_t;

  line_vec_t vecs [4];

  cmos_pixel_packer #(
    .IMG_WIDTH(8),
    .IMG_HEIGHT(2),
    .SKIP_FRAMES(2)
  ) dut (
    .pclk(pclk),
    .rst_n(rst_n),
    .vsync_i(vsync_i),
    .de_i(de_i),
    .pdata_i(pdata_i),
    .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en),
    .fifo_wdata(fifo_wdata),
    .frame_start(frame_start),
    .frame_done(frame_done),
    .line_cnt(line_cnt),
    .overflow(overflow),
    .frame_err(frame_err),
    .o_dbg_state(o_dbg_state)
  );

  // Clock
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every write must match the head of the expected queue
  always @(negedge pclk) begin
    if (rst_n) begin
      if (fifo_wr_en) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got %h expected no write", fifo_wdata);
        end else begin
          check("fifo_wdata", fifo_wdata, exp_q.pop_front());
        end
      end
      if (frame_start) n_fs++;
      if (frame_done)  n_fd++;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive_px(input logic [15:0] p, input logic full);
    de_i = 1'b1;
    pdata_i = p;
    fifo_full = full;
    tick();
    fifo_full = 1'b0;
  endtask

  task automatic idle(input int n);
    de_i = 1'b0;
    pdata_i = 16'd0;
    fifo_full = 1'b0;
    repeat (n) tick();
  endtask

  task automatic vsync_pulse();
    idle(2);
    vsync_i = 1'b1;
    tick();
    tick();
    vsync_i = 1'b0;
    idle(2);
  endtask

  task automatic plain_frame(input logic [15:0] base);
    vsync_pulse();
    for (int l = 0; l < 2; l++) begin
      for (int k = 0; k < 8; k++) drive_px(16'(base + 16'(l * 8 + k)), 1'b0);
      idle(3);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, 64'(fifo_wr_en), 64'd0);
    check({tag, "_wdata"}, fifo_wdata, 64'd0);
    check({tag, "_frame_start"}, 64'(frame_start), 64'd0);
    check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    check({tag, "_line_cnt"}, 64'(line_cnt), 64'd0);
    check({tag, "_overflow"}, 64'(overflow), 64'd0);
    check({tag, "_frame_err"}, 64'(frame_err), 64'd0);
    check({tag, "_state"}, 64'(o_dbg_state), 64'd0);
  endtask

  initial begin
    int fs0;
    int fd0;
    int wr0;
    logic [63:0] mw;
    logic [15:0] p;

    // Line vectors: two frames of two lines each
    vecs[0].n = 8;
    vecs[0].px = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008};
    vecs[0].full = 8'h00;
    vecs[0].nw = 2;
    vecs[0].w = '{64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005};
    vecs[0].exp_err = 1'b0;
    vecs[0].exp_ovf = 1'b0;
    vecs[1].n = 8;
    vecs[1].px = '{16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h0015, 16'h0016, 16'h0017, 16'h0018};
    vecs[1].full = 8'h80;
    vecs[1].nw = 1;
    vecs[1].w = '{64'h0014_0013_0012_0011, 64'd0};
    vecs[1].exp_err = 1'b0;
    vecs[1].exp_ovf = 1'b1;
    vecs[2].n = 8;
    vecs[2].px = '{16'h0021, 16'h0022, 16'h0023, 16'h0024, 16'h0025, 16'h0026, 16'h0027, 16'h0028};
    vecs[2].full = 8'h00;
    vecs[2].nw = 2;
    vecs[2].w = '{64'h0024_0023_0022_0021, 64'h0028_0027_0026_0025};
    vecs[2].exp_err = 1'b0;
    vecs[2].exp_ovf = 1'b1;
    vecs[3].n = 6;
    vecs[3].px = '{16'h0031, 16'h0032, 16'h0033, 16'h0034, 16'hAAAA, 16'hBBBB, 16'h0000, 16'h0000};
    vecs[3].full = 8'h00;
    vecs[3].nw = 2;
    vecs[3].w = '{64'h0034_0033_0032_0031, 64'h0000_0000_BBBB_AAAA};
    vecs[3].exp_err = 1'b1;
    vecs[3].exp_ovf = 1'b1;

    // Reset
    rst_n = 1'b0;
    vsync_i = 1'b0;
    de_i = 1'b0;
    pdata_i = 16'd0;
    fifo_full = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // Skip two frames, then accept the third
    wr0 = n_writes;
    plain_frame(16'h0100);
    plain_frame(16'h0200);
    check("skip_no_writes", 64'(n_writes - wr0), 64'd0);
    check("skip_no_start", 64'(n_fs), 64'd0);
    exp_q.push_back(64'h0004_0003_0002_0001);
    exp_q.push_back(64'h0008_0007_0006_0005);
    exp_q.push_back(64'h000C_000B_000A_0009);
    exp_q.push_back(64'h0010_000F_000E_000D);
    plain_frame(16'h0001);
    check("skip_writes", 64'(n_writes - wr0), 64'd4);
    check("skip_start", 64'(n_fs), 64'd1);
    check("skip_done", 64'(n_fd), 64'd1);
    check("skip_line_cnt", 64'(line_cnt), 64'd2);
    check("skip_overflow", 64'(overflow), 64'd0);
    check("skip_frame_err", 64'(frame_err), 64'd0);
    check("skip_state_done", 64'(o_dbg_state), 64'd2);
    check("skip_queue_empty", 64'(exp_q.size()), 64'd0);

    // Table-driven lines: packing, backpressure, short line
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        fs0 = n_fs;
        vsync_pulse();
        check("vec_frame_start", 64'(n_fs), 64'(fs0 + 1));
      end
      fd0 = n_fd;
      for (int k = 0; k < vecs[i].nw; k++) exp_q.push_back(vecs[i].w[k]);
      for (int k = 0; k < vecs[i].n; k++) drive_px(vecs[i].px[k], vecs[i].full[k]);
      idle(3);
      check("vec_line_cnt", 64'(line_cnt), 64'((i % 2) + 1));
      check("vec_frame_err", 64'(frame_err), 64'(vecs[i].exp_err));
      check("vec_overflow", 64'(overflow), 64'(vecs[i].exp_ovf));
      check("vec_queue_empty", 64'(exp_q.size()), 64'd0);
      check("vec_frame_done", 64'(n_fd), 64'(fd0 + (i % 2)));
    end

    // Reset in the middle of a line
    vsync_pulse();
    drive_px(16'h7001, 1'b0);
    drive_px(16'h7002, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    idle(2);
    rst_n = 1'b1;
    idle(2);
    fs0 = n_fs;
    wr0 = n_writes;
    plain_frame(16'h0300);
    plain_frame(16'h0400);
    check("rst_skip_no_writes", 64'(n_writes - wr0), 64'd0);
    check("rst_skip_no_start", 64'(n_fs), 64'(fs0));
    vsync_pulse();
    check("rst_accept_start", 64'(n_fs), 64'(fs0 + 1));
    check("rst_flags_clear", 64'({overflow, frame_err}), 64'd0);

    // Short frame: one full line, a partial line, then vsync
    exp_q.push_back(64'h0054_0053_0052_0051);
    exp_q.push_back(64'h0058_0057_0056_0055);
    for (int k = 0; k < 8; k++) drive_px(16'(16'h0051 + 16'(k)), 1'b0);
    idle(3);
    check("short_line1_cnt", 64'(line_cnt), 64'd1);
    check("short_line1_err", 64'(frame_err), 64'd0);
    drive_px(16'h0061, 1'b0);
    drive_px(16'h0062, 1'b0);
    drive_px(16'h0063, 1'b0);
    fs0 = n_fs;
    fd0 = n_fd;
    de_i = 1'b0;
    vsync_i = 1'b1;
    tick();
    tick();
    vsync_i = 1'b0;
    idle(3);
    check("short_frame_start", 64'(n_fs), 64'(fs0 + 1));
    check("short_no_done", 64'(n_fd), 64'(fd0));
    check("short_line_cnt", 64'(line_cnt), 64'd0);
    check("short_frame_err", 64'(frame_err), 64'd1);
    check("short_no_flush", 64'(exp_q.size()), 64'd0);

    // Following full frame with random pixels completes normally
    for (int l = 0; l < 2; l++) begin
      mw = 64'd0;
      for (int k = 0; k < 8; k++) begin
        p = 16'($urandom_range(0, 65535));
        mw[16 * (k % 4) +: 16] = p;
        if (k % 4 == 3) exp_q.push_back(mw);
        drive_px(p, 1'b0);
      end
      idle(3);
    end
    check("rand_frame_done", 64'(n_fd), 64'(fd0 + 1));
    check("rand_line_cnt", 64'(line_cnt), 64'd2);
    check("rand_state_done", 64'(o_dbg_state), 64'd2);
    check("rand_overflow", 64'(overflow), 64'd0);

    idle(3);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
